// File: rtl/appear_pkg.sv
// appear_pkg: shared widths and types for the appear ping-pong buffer
package appear_pkg;
  localparam int APPEAR_ADDR_W = 8;
  localparam int APPEAR_DATA_W = 1;
  localparam int APPEAR_DEPTH  = 256;
  localparam int APPEAR_BANKS  = 2;
  typedef logic [APPEAR_ADDR_W-1:0] appear_addr_t;
  typedef logic [1:0] bank_cnt_t;
endpackage

// File: rtl/appear_pipo_buffer_if.sv
// appear_pipo_buffer_if: producer/consumer bus of the ping-pong buffer; status signals exist only with APPEAR_PIPO_STATUS_EN
interface appear_pipo_buffer_if
  import appear_pkg::*;
#(
  parameter int ADDR_WIDTH = APPEAR_ADDR_W,
  parameter int DATA_WIDTH = APPEAR_DATA_W
);
  logic [ADDR_WIDTH-1:0] i_address0;
  logic                  i_ce0;
  logic                  i_we0;
  logic [DATA_WIDTH-1:0] i_d0;
  logic [DATA_WIDTH-1:0] i_q0;
  logic                  i_write;
  logic                  i_full_n;
  logic [ADDR_WIDTH-1:0] t_address0;
  logic                  t_ce0;
  logic [DATA_WIDTH-1:0] t_q0;
  logic                  t_read;
  logic                  t_empty_n;
`ifdef APPEAR_PIPO_STATUS_EN
  bank_cnt_t             occupancy;
  logic                  err_overflow;
  logic                  err_underflow;
`endif
  modport slave (
    input  i_address0, i_ce0, i_we0, i_d0, i_write, t_address0, t_ce0, t_read,
    output i_q0, i_full_n, t_q0, t_empty_n
`ifdef APPEAR_PIPO_STATUS_EN
    , output occupancy, err_overflow, err_underflow
`endif
  );
  modport master (
    output i_address0, i_ce0, i_we0, i_d0, i_write, t_address0, t_ce0, t_read,
    input  i_q0, i_full_n, t_q0, t_empty_n
`ifdef APPEAR_PIPO_STATUS_EN
    , input occupancy, err_overflow, err_underflow
`endif
  );
endinterface

// File: rtl/appear_pipo_ram.sv
// appear_pipo_ram: one bank, read-first read/write port plus read port, 1-cycle latency, held outputs
module appear_pipo_ram #(
  parameter int DW    = 1,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_ce_i,
  input  logic          a_we_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [DW-1:0] a_d_i,
  output logic [DW-1:0] a_q_o,
  input  logic          b_ce_i,
  input  logic [AW-1:0] b_addr_i,
  output logic [DW-1:0] b_q_o
);
  logic [DW-1:0] mem_q [DEPTH];
  // storage is never cleared, so it gets no reset
  always_ff @(posedge clk)
    if (a_ce_i && a_we_i) mem_q[a_addr_i] <= a_d_i;
  // read registers load on access and hold otherwise
  always_ff @(posedge clk)
    if (rst) begin
      a_q_o <= '0;
      b_q_o <= '0;
    end else begin
      a_q_o <= a_ce_i ? mem_q[a_addr_i] : a_q_o;
      b_q_o <= b_ce_i ? mem_q[b_addr_i] : b_q_o;
    end
endmodule

// File: rtl/appear_pipo_buffer.sv
// appear_pipo_buffer: two-bank ping-pong flag buffer between count and threshold; APPEAR_PIPO_STATUS_EN adds occupancy and sticky error flags
module appear_pipo_buffer
  import appear_pkg::*;
#(
  parameter int DATA_WIDTH = APPEAR_DATA_W,
  parameter int ADDR_WIDTH = APPEAR_ADDR_W,
  parameter int DEPTH      = APPEAR_DEPTH,
  parameter int BUF_COUNT  = APPEAR_BANKS
) (
  input logic clk,
  input logic reset,
  appear_pipo_buffer_if.slave bus
);
  if (BUF_COUNT != 2 || DEPTH != 2**ADDR_WIDTH) begin : g_bad_cfg
    $error("appear_pipo_buffer needs BUF_COUNT==2 and DEPTH==2**ADDR_WIDTH");
  end
  logic iptr_q, iptr_d, tptr_q, tptr_d, isel_q, isel_d, tsel_q, tsel_d;
  bank_cnt_t cnt_q, cnt_d;
  logic full_n, empty_n, commit, rel, iacc;
  logic [DATA_WIDTH-1:0] a_q [2];
  logic [DATA_WIDTH-1:0] b_q [2];
  // illegal commits/releases fall out of the full/empty qualification; isel/tsel remember which bank owns the held read data
  always_comb begin
    full_n  = cnt_q != 2'd2;
    empty_n = cnt_q != 2'd0;
    commit  = bus.i_write & full_n;
    rel     = bus.t_read & empty_n;
    iacc    = bus.i_ce0 & full_n & ~reset;
    iptr_d  = iptr_q ^ commit;
    tptr_d  = tptr_q ^ rel;
    cnt_d   = cnt_q + bank_cnt_t'(commit) - bank_cnt_t'(rel);
    isel_d  = iacc ? iptr_q : isel_q;
    tsel_d  = bus.t_ce0 ? tptr_q : tsel_q;
  end
  // pointer and occupancy state
  always_ff @(posedge clk)
    if (reset) begin
      iptr_q <= 1'b0;
      tptr_q <= 1'b0;
      cnt_q  <= '0;
      isel_q <= 1'b0;
      tsel_q <= 1'b0;
    end else begin
      iptr_q <= iptr_d;
      tptr_q <= tptr_d;
      cnt_q  <= cnt_d;
      isel_q <= isel_d;
      tsel_q <= tsel_d;
    end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    appear_pipo_ram #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH), .DEPTH(DEPTH)) u_ram (
      .clk      (clk),
      .rst      (reset),
      .a_ce_i   (iacc && iptr_q == 1'(b)),
      .a_we_i   (bus.i_we0),
      .a_addr_i (bus.i_address0),
      .a_d_i    (bus.i_d0),
      .a_q_o    (a_q[b]),
      .b_ce_i   (bus.t_ce0 && tptr_q == 1'(b)),
      .b_addr_i (bus.t_address0),
      .b_q_o    (b_q[b])
    );
  end
  assign bus.i_full_n  = full_n;
  assign bus.t_empty_n = empty_n;
  assign bus.i_q0      = a_q[isel_q];
  assign bus.t_q0      = b_q[tsel_q];
`ifdef APPEAR_PIPO_STATUS_EN
  logic ovf_q, unf_q;
  // sticky protocol-violation flags, cleared only by reset
  always_ff @(posedge clk)
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (bus.i_write & ~full_n);
      unf_q <= unf_q | (bus.t_read & ~empty_n);
    end
  assign bus.occupancy     = cnt_q;
  assign bus.err_overflow  = ovf_q;
  assign bus.err_underflow = unf_q;
`endif
endmodule

// File: doc/appear_pipo_buffer.md
Name: appear_pipo_buffer

Overview:
- Ping-pong (PIPO) buffer between the byte-count process and the threshold process inside the per-iteration dataflow region of the byte-count accelerator.
- The producer (count) fills a 256-entry "byte value appeared" bank, then commits it. The consumer (threshold) reads the committed bank while the producer fills the other bank.
- Exposes i_full_n / t_empty_n / i_write / t_read exactly as the deadlock detector probes them.

Parameters:
- DATA_WIDTH, 1, bits per entry (appear flag per byte value)
- ADDR_WIDTH, 8, entry address width
- DEPTH, 256, entries per bank (must equal 2**ADDR_WIDTH)
- BUF_COUNT, 2, number of banks (fixed 2; other values rejected at elaboration)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- i_address0  in  ADDR_WIDTH  producer address
- i_ce0  in  1  producer access enable
- i_we0  in  1  producer write enable (qualified by i_ce0)
- i_d0  in  DATA_WIDTH  producer write data
- i_q0  out  DATA_WIDTH  producer read data (read-modify-write of flags)
- i_write  in  1  producer commits current bank (pulse, 1 cycle)
- i_full_n  out  1  producer may own a bank (not all banks committed)
- t_address0  in  ADDR_WIDTH  consumer address
- t_ce0  in  1  consumer read enable
- t_q0  out  DATA_WIDTH  consumer read data
- t_read  in  1  consumer releases current bank (pulse, 1 cycle)
- t_empty_n  out  1  at least one committed bank available

Behaviour:
- State: iptr (producer bank, 1 bit), tptr (consumer bank, 1 bit), cnt (committed banks, 0..2).
- Reset: iptr=0, tptr=0, cnt=0. Outputs: i_full_n=1, t_empty_n=0, i_q0=0, t_q0=0. Memory contents are not cleared.
- Reset asserted mid-operation discards all commits in the same cycle. Pending i_write/t_read in the reset cycle are ignored.
- i_full_n = (cnt != 2). t_empty_n = (cnt != 0). Both are registered-state derived, with no combinational path from i_write/t_read.
- Producer access: when i_ce0 is high and i_full_n is high, the access targets bank iptr.
  - Write: i_we0=1 writes i_d0 at the clock edge.
  - Read: i_q0 is valid 1 cycle after i_ce0 and holds its value until the next access.
  - i_ce0 while i_full_n=0 is ignored (no write, i_q0 holds).
- Consumer access: t_ce0 reads bank tptr with 1-cycle latency and t_q0 holds. t_ce0 while t_empty_n=0 returns stale data. This is legal but not meaningful.
- Commit: i_write with i_full_n=1 sets iptr <= ~iptr and increments cnt. i_write while full is ignored.
- Release: t_read with t_empty_n=1 sets tptr <= ~tptr and decrements cnt. t_read while empty is ignored.
- Simultaneous valid i_write and t_read: both pointers toggle and cnt is unchanged.
- cnt=2 with both events in the same cycle: the commit is ignored (not full_n) and the release proceeds, so cnt=1.
- cnt=0 with both events in the same cycle: the release is ignored and the commit proceeds, so cnt=1.
- Same-cycle write/read of the same address in different banks is independent.
- Producer and consumer never alias the same bank while cnt=1: iptr != tptr.
- Commit-to-visible latency: t_empty_n rises the cycle after i_write.

Optional Feature:
- Macro: APPEAR_PIPO_STATUS_EN.
- Defined: adds outputs
  - occupancy[1:0] = cnt
  - err_overflow: sticky, set by i_write while i_full_n=0
  - err_underflow: sticky, set by t_read while t_empty_n=0
  - Both error flags are cleared only by reset.
- Undefined: those ports are absent, and illegal commits/releases are silently ignored as described above.

Decomposition:
- Shared package appear_pkg holds:
  - APPEAR_ADDR_W=8, APPEAR_DATA_W=1, APPEAR_DEPTH=256, APPEAR_BANKS=2
  - typedef appear_addr_t
  - typedef bank_cnt_t (2-bit)
- Sub-module appear_pipo_ram: single bank, one synchronous write/read port plus one synchronous read port, 1-cycle read latency. It is instantiated twice and muxed by iptr/tptr.
- Pointer/count control stays in the top module.

Test Plan:
- Reset then idle: i_full_n=1, t_empty_n=0, i_q0=0, t_q0=0 for 10 cycles.
- Fill bank 0: write flag=1 at addr 0x41 and 0x7F, then pulse i_write. Next cycle t_empty_n=1. Reading t_address0=0x41 gives t_q0=1 one cycle later, and 0x42 gives 0.
- Two commits with no release: i_full_n drops to 0. A third i_write and a write to 0x10 are ignored. After a t_read, i_full_n=1 and the consumer sees bank 1 data.
- cnt=1 with i_write and t_read in the same cycle: cnt stays 1, both pointers toggle, and the consumer now reads the newly committed bank.
- Assert reset with cnt=2: the next cycle shows i_full_n=1 and t_empty_n=0. A commit then lands in bank 0 again.
- With APPEAR_PIPO_STATUS_EN: t_read at cnt=0 sets err_underflow=1, which stays set until reset, and occupancy tracks 0→1→2→1.
